// File: rtl/busca_instrucao.sv
// Instruction fetch: one outstanding request, registered word out; >=2 cycles request to valid.
// Parar holds the output slot and blocks new requests; Desvio redirects and squashes in-flight data.
`timescale 1ns/1ps
module busca_instrucao #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        MemReq,
  output logic [31:0] MemEndereco,
  input  logic        MemAceito,
  input  logic        MemDadoValido,
  input  logic [31:0] MemDado,
  input  logic        Parar,
  input  logic        Desvio,
  input  logic [31:0] DesvioAlvo,
  output logic [31:0] Instrucao,
  output logic        InstrValida,
  output logic [31:0] PCAtual,
  output logic [31:0] PCMais4
);

  typedef enum logic {BUSCA = 1'b0, ESPERA = 1'b1} estado_t;

  localparam logic [31:0] PC_RST = {PC_INICIAL[31:2], 2'b00};

  estado_t     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_atual_q, pc_atual_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_vld_q, instr_vld_d;
  logic        descartar_q, descartar_d;
  logic        mem_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUSCA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUSCA:  if (mem_req && MemAceito) state_d = ESPERA;
      ESPERA: if (MemDadoValido) state_d = BUSCA;
      default: state_d = BUSCA;
    endcase
  end

  // Request only when the slot is free or drains this edge; rst_n gates it while reset is held.
  always_comb begin
    mem_req = rst_n && (state_q == BUSCA) && !Desvio && (!instr_vld_q || !Parar);
  end

  always_comb begin
    pc_d        = pc_q;
    pc_atual_d  = pc_atual_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    descartar_d = descartar_q;
    if (Desvio) begin
      pc_d        = {DesvioAlvo[31:2], 2'b00};
      instr_vld_d = 1'b0;
      // A word still in flight belongs to the old path and must be dropped when it lands.
      if (state_q == ESPERA) descartar_d = !MemDadoValido;
    end else begin
      if (instr_vld_q && !Parar) instr_vld_d = 1'b0;
      if ((state_q == ESPERA) && MemDadoValido) begin
        if (descartar_q) begin
          descartar_d = 1'b0;
        end else begin
          instr_d     = MemDado;
          pc_atual_d  = pc_q;
          instr_vld_d = 1'b1;
          pc_d        = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_RST;
      pc_atual_q  <= PC_RST;
      instr_q     <= 32'h0;
      instr_vld_q <= 1'b0;
      descartar_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_atual_q  <= pc_atual_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      descartar_q <= descartar_d;
    end
  end

  assign MemReq      = mem_req;
  assign MemEndereco = pc_q;
  assign Instrucao   = instr_q;
  assign InstrValida = instr_vld_q;
  assign PCAtual     = pc_atual_q;
  assign PCMais4     = pc_atual_q + 32'd4;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: scenario tasks with a scoreboard of expected {word, pc} per fetch.
`timescale 1ns/1ps
module tb_busca_instrucao;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_aceito, mem_dv, parar, desvio, instr_vld;
  logic [31:0] mem_end, mem_dado, desvio_alvo, instr, pc_atual, pc_mais4;

  logic        w_req, w_aceito, w_dv, w_vld;
  logic [31:0] w_end, w_dado, w_instr, w_pc_atual, w_pc_mais4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc;
  int          checks;
  int          errors;

  busca_instrucao u_dut (
    .clk(clk), .rst_n(rst_n), .MemReq(mem_req), .MemEndereco(mem_end),
    .MemAceito(mem_aceito), .MemDadoValido(mem_dv), .MemDado(mem_dado),
    .Parar(parar), .Desvio(desvio), .DesvioAlvo(desvio_alvo),
    .Instrucao(instr), .InstrValida(instr_vld), .PCAtual(pc_atual), .PCMais4(pc_mais4)
  );

  busca_instrucao #(.PC_INICIAL(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .MemReq(w_req), .MemEndereco(w_end),
    .MemAceito(w_aceito), .MemDadoValido(w_dv), .MemDado(w_dado),
    .Parar(1'b0), .Desvio(1'b0), .DesvioAlvo(32'h0),
    .Instrucao(w_instr), .InstrValida(w_vld), .PCAtual(w_pc_atual), .PCMais4(w_pc_mais4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_req: MemReq never rose within 20 cycles (pc expected %h)", exp_pc);
    end
  endtask

  task automatic fetch_one(input logic [31:0] data, input int lat, input logic hold);
    bit   ok;
    exp_t e;
    wait_req(ok);
    if (!ok) return;
    checks++;
    if (mem_end !== exp_pc) begin
      errors++;
      $display("FAIL fetch_addr: MemEndereco=%h expected %h", mem_end, exp_pc);
    end
    mem_aceito = 1'b1;
    step();
    mem_aceito = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL espera_req: MemReq=%b expected 0", mem_req);
    end
    repeat (lat - 1) step();
    parar    = hold;
    mem_dv   = 1'b1;
    mem_dado = data;
    sb.push_back('{instr: data, pc: exp_pc});
    step();
    mem_dv = 1'b0;
    exp_pc = exp_pc + 32'd4;
    checks++;
    if (instr_vld !== 1'b1) begin
      errors++;
      $display("FAIL fetch_vld: InstrValida=%b expected 1", instr_vld);
    end
    e = sb.pop_front();
    checks++;
    if (instr !== e.instr || pc_atual !== e.pc || pc_mais4 !== e.pc + 32'd4) begin
      errors++;
      $display("FAIL fetch_data: Instrucao=%h PCAtual=%h PCMais4=%h expected %h %h %h",
               instr, pc_atual, pc_mais4, e.instr, e.pc, e.pc + 32'd4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_pc = 32'h0;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || instr_vld !== 1'b0 || instr !== 32'h0 ||
        pc_atual !== 32'h0 || mem_end !== 32'h0 || pc_mais4 !== 32'h4) begin
      errors++;
      $display("FAIL reset: req=%b vld=%b instr=%h pcatual=%h end=%h mais4=%h expected 0 0 0 0 0 4",
               mem_req, instr_vld, instr, pc_atual, mem_end, pc_mais4);
    end
    checks++;
    if (w_end !== 32'hFFFF_FFFC || w_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap: end=%h req=%b expected fffffffc 0", w_end, w_req);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    fetch_one(32'h0123_4567, 1, 1'b0);
    checks++;
    if (mem_end !== 32'h4 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL basic_next: MemEndereco=%h MemReq=%b expected 4 1", mem_end, mem_req);
    end
  endtask

  task automatic test_parar();
    fetch_one(32'hCAFE_F00D, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr !== 32'hCAFE_F00D || instr_vld !== 1'b1 || mem_req !== 1'b0 || pc_atual !== 32'h4) begin
        errors++;
        $display("FAIL parar_hold: instr=%h vld=%b req=%b pcatual=%h expected cafef00d 1 0 4",
                 instr, instr_vld, mem_req, pc_atual);
      end
      step();
    end
    parar = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_end !== 32'h8) begin
      errors++;
      $display("FAIL parar_resume: req=%b end=%h expected 1 8", mem_req, mem_end);
    end
    step();
    checks++;
    if (instr_vld !== 1'b0) begin
      errors++;
      $display("FAIL parar_consume: vld=%b expected 0", instr_vld);
    end
  endtask

  task automatic test_desvio_espera();
    bit ok;
    wait_req(ok);
    mem_aceito = 1'b1;
    step();
    mem_aceito  = 1'b0;
    desvio      = 1'b1;
    desvio_alvo = 32'h0000_0042;
    step();
    desvio = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL desvio_wait: MemReq=%b expected 0", mem_req);
    end
    step();
    mem_dv   = 1'b1;
    mem_dado = 32'hBAD0_BAD0;
    step();
    mem_dv = 1'b0;
    checks++;
    if (instr_vld !== 1'b0 || mem_end !== 32'h40 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL desvio_discard: vld=%b end=%h req=%b expected 0 40 1", instr_vld, mem_end, mem_req);
    end
    // redirect on the same edge the data lands
    mem_aceito = 1'b1;
    step();
    mem_aceito  = 1'b0;
    desvio      = 1'b1;
    desvio_alvo = 32'h0000_0080;
    mem_dv      = 1'b1;
    mem_dado    = 32'h7777_7777;
    step();
    desvio = 1'b0;
    mem_dv = 1'b0;
    #1;
    checks++;
    if (instr_vld !== 1'b0 || mem_end !== 32'h80 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL desvio_same_edge: vld=%b end=%h req=%b expected 0 80 1", instr_vld, mem_end, mem_req);
    end
    exp_pc = 32'h80;
  endtask

  task automatic test_desvio_parar();
    fetch_one(32'h1111_2222, 1, 1'b1);
    desvio      = 1'b1;
    desvio_alvo = 32'h0000_0100;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL desvio_parar_req: MemReq=%b expected 0", mem_req);
    end
    step();
    desvio = 1'b0;
    parar  = 1'b0;
    #1;
    checks++;
    if (instr_vld !== 1'b0 || mem_end !== 32'h100) begin
      errors++;
      $display("FAIL desvio_parar: vld=%b end=%h expected 0 100", instr_vld, mem_end);
    end
    exp_pc = 32'h100;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) fetch_one($urandom, 1 + (i % 3), 1'b0);
  endtask

  task automatic test_wrap();
    checks++;
    if (w_end !== 32'hFFFF_FFFC || w_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_start: end=%h req=%b expected fffffffc 1", w_end, w_req);
    end
    w_aceito = 1'b1;
    step();
    w_aceito = 1'b0;
    w_dv     = 1'b1;
    w_dado   = 32'h5A5A_A5A5;
    step();
    w_dv = 1'b0;
    checks++;
    if (w_vld !== 1'b1 || w_instr !== 32'h5A5A_A5A5 || w_pc_atual !== 32'hFFFF_FFFC ||
        w_pc_mais4 !== 32'h0 || w_end !== 32'h0) begin
      errors++;
      $display("FAIL wrap: vld=%b instr=%h pcatual=%h mais4=%h end=%h expected 1 5a5aa5a5 fffffffc 0 0",
               w_vld, w_instr, w_pc_atual, w_pc_mais4, w_end);
    end
  endtask

  task automatic test_reset_espera();
    bit ok;
    wait_req(ok);
    mem_aceito = 1'b1;
    step();
    mem_aceito = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_vld !== 1'b0 || mem_end !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: req=%b vld=%b end=%h expected 0 0 0", mem_req, instr_vld, mem_end);
    end
    step();
    rst_n    = 1'b1;
    mem_dv   = 1'b1;
    mem_dado = $urandom;
    step();
    mem_dv = 1'b0;
    checks++;
    if (instr_vld !== 1'b0 || mem_end !== 32'h0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_stale: vld=%b end=%h req=%b expected 0 0 1", instr_vld, mem_end, mem_req);
    end
    exp_pc = 32'h0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    mem_aceito  = 1'b0;
    mem_dv      = 1'b0;
    mem_dado    = 32'h0;
    parar       = 1'b0;
    desvio      = 1'b0;
    desvio_alvo = 32'h0;
    w_aceito    = 1'b0;
    w_dv        = 1'b0;
    w_dado      = 32'h0;
    exp_pc      = 32'h0;
    test_reset();
    test_basic();
    test_parar();
    test_desvio_espera();
    test_desvio_parar();
    test_back_to_back();
    test_wrap();
    test_reset_espera();
    test_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
